// File: rtl/rv32im_alu_issue_pkg.sv
// Shared constants and types for the rv32im_alu issue stage: RV32 opcodes, ALU opcode values,
// and the decoded-entry record held by the handshake registers.
package rv32im_alu_issue_pkg;

    localparam int DATA_W   = 32;
    localparam int ALU_OP_W = 4;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        alu_op_e           alu_op;
        logic [4:0]        rd;
        logic              rd_we;
        logic              illegal;
    } issue_t;

    // alt selects SUB/SRA for funct3 000/101 (funct7[5] set)
    function automatic alu_op_e alu_op_for(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32im_alu_issue_decode.sv
// Combinational decode of OP, OP-IMM, LUI and AUIPC into ALU operands, opcode and write-back info.
module rv32im_alu_decode
    import rv32im_alu_issue_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output issue_t            dec
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        // NOTE: every field gets a default first so no path leaves dec unassigned (no latch).
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.rd      = instr[11:7];
        dec.illegal = 1'b1;

        case (opcode)
            OPC_OP: begin
                dec.op1 = rs1_data;
                dec.op2 = rs2_data;
                if (f7 == 7'h00) begin
                    dec.alu_op  = alu_op_for(f3, 1'b0);
                    dec.illegal = 1'b0;
                end else if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)) begin
                    dec.alu_op  = alu_op_for(f3, 1'b1);
                    dec.illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.op1 = rs1_data;
                dec.op2 = {{20{instr[31]}}, instr[31:20]};
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediates carry only a 5-bit shamt; upper bits are funct7
                    dec.op2 = {27'b0, instr[24:20]};
                    if (f7 == 7'h00) begin
                        dec.alu_op  = alu_op_for(f3, 1'b0);
                        dec.illegal = 1'b0;
                    end else if (f7 == 7'h20 && f3 == 3'b101) begin
                        dec.alu_op  = ALU_SRA;
                        dec.illegal = 1'b0;
                    end
                end else begin
                    dec.alu_op  = alu_op_for(f3, 1'b0);
                    dec.illegal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec.op2     = {instr[31:12], 12'b0};
                dec.illegal = 1'b0;
            end
            OPC_AUIPC: begin
                dec.op1     = pc;
                dec.op2     = {instr[31:12], 12'b0};
                dec.illegal = 1'b0;
            end
            default: ;
        endcase

        dec.rd_we = !dec.illegal && (dec.rd != 5'd0);
    end

endmodule

// File: rtl/rv32im_alu_issue.sv
// Decode/issue stage feeding rv32im_alu with valid/ready flow control.
// Define ALU_ISSUE_SKID_EN for a main+skid buffer with a registered ready_o.
module rv32im_alu_issue
    import rv32im_alu_issue_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [DATA_W-1:0]   instr_i,
    input  logic [DATA_W-1:0]   pc_i,
    input  logic [DATA_W-1:0]   rs1_data_i,
    input  logic [DATA_W-1:0]   rs2_data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [DATA_W-1:0]   aluoperand_1_o,
    output logic [DATA_W-1:0]   aluoperand_2_o,
    output logic [ALU_OP_W-1:0] alu_opcode_o,
    output logic [4:0]          rd_addr_o,
    output logic                rd_we_o,
    output logic                illegal_o
);

    issue_t dec;
    issue_t main_q;
    logic   main_valid_q;
    logic   accept;

    rv32im_alu_decode u_decode (
        .instr    (instr_i),
        .pc       (pc_i),
        .rs1_data (rs1_data_i),
        .rs2_data (rs2_data_i),
        .dec      (dec)
    );

    assign accept = valid_i && ready_o;

`ifdef ALU_ISSUE_SKID_EN
    issue_t skid_q;
    logic   skid_valid_q;

    // Ready depends only on local state and flush, never on ready_i
    assign ready_o = !skid_valid_q && !flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else if (flush_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!main_valid_q || ready_i) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q       <= dec;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            // Stalled with main occupied: park the new entry in the skid slot
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign ready_o = (!main_valid_q || ready_i) && !flush_i;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n_i) begin
            main_valid_q <= 1'b0;
            main_q       <= '0;
        end else if (flush_i) begin
            main_valid_q <= 1'b0;
        end else if (accept) begin
            main_q       <= dec;
            main_valid_q <= 1'b1;
        end else if (ready_i) begin
            main_valid_q <= 1'b0;
        end
    end
`endif

    assign valid_o        = main_valid_q;
    assign aluoperand_1_o = main_q.op1;
    assign aluoperand_2_o = main_q.op2;
    assign alu_opcode_o   = main_q.alu_op;
    assign rd_addr_o      = main_q.rd;
    assign rd_we_o        = main_q.rd_we;
    assign illegal_o      = main_q.illegal;

endmodule

// File: tb/tb_rv32im_alu_issue.sv
// Self-checking bench for rv32im_alu_issue: directed cases plus randomized traffic against a
// queue-based reference model of decode and flow control.
module tb_rv32im_alu_issue;
    import rv32im_alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] op1_o;
    logic [31:0] op2_o;
    logic [3:0]  aluop_o;
    logic [4:0]  rd_o;
    logic        we_o;
    logic        ill_o;

    rv32im_alu_issue dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .flush_i        (flush),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .instr_i        (instr),
        .pc_i           (pc),
        .rs1_data_i     (rs1),
        .rs2_data_i     (rs2),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .aluoperand_1_o (op1_o),
        .aluoperand_2_o (op2_o),
        .alu_opcode_o   (aluop_o),
        .rd_addr_o      (rd_o),
        .rd_we_o        (we_o),
        .illegal_o      (ill_o)
    );

    always #5 clk = ~clk;

`ifdef ALU_ISSUE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        alu_op_e     op;
        logic [4:0]  rd;
        bit          we;
        bit          illegal;
        bit          chk_ops;
    } exp_t;

    // Reference decode straight from the instruction-set rules
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] p,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t    e;
        alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        int      opc = int'(i & 32'h7F);
        int      f3  = int'((i >> 12) & 32'h7);
        int      f7  = int'(i >> 25);
        e.rd      = i[11:7];
        e.op1     = 0;
        e.op2     = 0;
        e.op      = ALU_ADD;
        e.illegal = 1;
        e.chk_ops = 1;
        if (opc == 'h33) begin
            e.op1 = a;
            e.op2 = b;
            if (f7 == 0) begin e.illegal = 0; e.op = base[f3]; end
            else if (f7 == 'h20 && f3 == 0) begin e.illegal = 0; e.op = ALU_SUB; end
            else if (f7 == 'h20 && f3 == 5) begin e.illegal = 0; e.op = ALU_SRA; end
        end else if (opc == 'h13) begin
            e.op1 = a;
            if (f3 == 1 || f3 == 5) begin
                e.op2 = (i >> 20) & 32'h1F;
                if (f7 == 0) begin e.illegal = 0; e.op = base[f3]; end
                else if (f7 == 'h20 && f3 == 5) begin e.illegal = 0; e.op = ALU_SRA; end
            end else begin
                e.op2 = 32'($signed(i) >>> 20);
                e.illegal = 0;
                e.op = base[f3];
            end
        end else if (opc == 'h37) begin
            e.op2 = i & 32'hFFFFF000;
            e.illegal = 0;
        end else if (opc == 'h17) begin
            e.op1 = p;
            e.op2 = i & 32'hFFFFF000;
            e.illegal = 0;
        end
        if (e.illegal && (opc == 'h33 || opc == 'h13)) e.chk_ops = 0;
        e.we = !e.illegal && (e.rd != 0);
        return e;
    endfunction

    exp_t q[$];
    exp_t samp_exp;
    bit   samp_acc = 0;
    bit   samp_out = 0;

    // Compare process: checks DUT against model every cycle, then samples handshakes
    always @(negedge clk) begin
        bit exp_ready;
        if (rst_n) begin
            exp_ready = (SKID ? (q.size() < 2) : (q.size() == 0 || ready_i)) && !flush;
            check("ready_o", 32'(ready_o), 32'(exp_ready));
            check("valid_o", 32'(valid_o), 32'(q.size() > 0));
            if (valid_o && q.size() > 0) begin
                if (q[0].chk_ops) begin
                    check("op1", op1_o, q[0].op1);
                    check("op2", op2_o, q[0].op2);
                    check("alu_opcode", 32'(aluop_o), 32'(q[0].op));
                end
                if (!q[0].illegal) check("rd_addr", 32'(rd_o), 32'(q[0].rd));
                check("rd_we", 32'(we_o), 32'(q[0].we));
                check("illegal", 32'(ill_o), 32'(q[0].illegal));
            end
            samp_acc = valid_i && ready_o;
            samp_out = valid_o && ready_i;
        end else begin
            samp_acc = 0;
            samp_out = 0;
        end
        samp_exp = model(instr, pc, rs1, rs2);
    end

    always @(posedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (samp_out && q.size() > 0) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (samp_acc) q.push_back(samp_exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] a, input logic [31:0] b);
        instr = i; pc = p; rs1 = a; rs2 = b; valid_i = 1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ready_o) begin
                tick();
                valid_i = 0;
                return;
            end
            tick();
        end
        valid_i = 0;
        timeout("send");
    endtask

    task automatic expect_out(input string name, input logic [31:0] e1, input logic [31:0] e2,
                              input alu_op_e eop, input logic [4:0] erd, input logic ewe,
                              input logic eill);
        @(negedge clk);
        check({name, ".valid"}, 32'(valid_o), 32'd1);
        check({name, ".op1"}, op1_o, e1);
        check({name, ".op2"}, op2_o, e2);
        check({name, ".opcode"}, 32'(aluop_o), 32'(eop));
        check({name, ".rd"}, 32'(rd_o), 32'(erd));
        check({name, ".we"}, 32'(we_o), 32'(ewe));
        check({name, ".illegal"}, 32'(ill_o), 32'(eill));
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && (valid_i || valid_o); k++) begin
            bit acc;
            @(negedge clk);
            acc = valid_i && ready_o;
            tick();
            if (acc) valid_i = 0;
        end
        if (valid_i || valid_o) timeout("drain");
        valid_i = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        logic [6:0]  opc;
        logic [6:0]  f7;
        case ($urandom_range(0, 5))
            0:       opc = OPC_OP;
            1, 2:    opc = OPC_OP_IMM;
            3:       opc = OPC_LUI;
            4:       opc = OPC_AUIPC;
            default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = r[31:25];
        endcase
        return {f7, r[24:7], opc};
    endfunction

    initial begin
        exp_t m;
        int   x0;

        // Pin the model against hand-computed decodes
        m = model(32'h403100B3, 0, 5, 7);
        check("model.sub.op", 32'(m.op), 32'(ALU_SUB));
        check("model.sub.we", 32'(m.we), 32'd1);
        m = model(32'hFFF00293, 0, 0, 0);
        check("model.addi.op2", m.op2, 32'hFFFFFFFF);
        m = model(32'h4040D113, 0, 0, 0);
        check("model.srai.op2", m.op2, 32'd4);
        check("model.srai.op", 32'(m.op), 32'(ALU_SRA));
        m = model(32'h02208033, 0, 1, 2);
        check("model.mul.illegal", 32'(m.illegal), 32'd1);

        // Reset state
        tick(); tick();
        @(negedge clk);
        check("reset.valid", 32'(valid_o), 32'd0);
        check("reset.op1", op1_o, 32'd0);
        check("reset.op2", op2_o, 32'd0);
        check("reset.illegal", 32'(ill_o), 32'd0);
        tick();
        rst_n = 1;
        tick();

        // Directed decodes with one-cycle latency
        ready_i = 1;
        send(32'h403100B3, 32'h100, 5, 7);
        expect_out("sub", 5, 7, ALU_SUB, 1, 1, 0);
        send(32'hFFF00293, 32'h104, 0, 9);
        expect_out("addi", 0, 32'hFFFFFFFF, ALU_ADD, 5, 1, 0);
        send(32'h4040D113, 32'h108, 32'h80000000, 0);
        expect_out("srai", 32'h80000000, 4, ALU_SRA, 2, 1, 0);
        send(32'h123451B7, 32'h10C, 32'hDEAD, 32'hBEEF);
        expect_out("lui", 0, 32'h12345000, ALU_ADD, 3, 1, 0);
        send(32'h00001217, 32'h2000, 0, 0);
        expect_out("auipc", 32'h2000, 32'h1000, ALU_ADD, 4, 1, 0);
        send(32'h02208033, 32'h110, 1, 2);
        @(negedge clk);
        check("mul.valid", 32'(valid_o), 32'd1);
        check("mul.illegal", 32'(ill_o), 32'd1);
        check("mul.we", 32'(we_o), 32'd0);
        send(32'h0000007F, 32'h114, 1, 2);
        expect_out("opc7f", 0, 0, ALU_ADD, 0, 0, 1);
        drain();

        // Back-to-back under a 3-cycle stall
        ready_i = 0;
        x0 = n_xfer;
        send(32'h002081B3, 0, 32'h11, 32'h22);
        instr = 32'h40208233; rs1 = 32'h33; rs2 = 32'h44; valid_i = 1;
        @(negedge clk);
        check("stall.ready_second", 32'(ready_o), 32'(SKID));
        tick();
        if (SKID) valid_i = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall.valid", 32'(valid_o), 32'd1);
            check("stall.hold_op1", op1_o, 32'h11);
            tick();
        end
        ready_i = 1;
        drain();
        check("stall.xfer_count", 32'(n_xfer - x0), 32'd2);

        // Flush with buffer loaded
        ready_i = 0;
        send(32'h00110093, 0, 1, 0);
        instr = 32'h00210113; rs1 = 2; valid_i = 1;
        @(negedge clk);
        tick();
        valid_i = 0;
        flush = 1;
        @(negedge clk);
        check("flush.ready", 32'(ready_o), 32'd0);
        tick();
        flush = 0;
        @(negedge clk);
        check("flush.valid", 32'(valid_o), 32'd0);
        ready_i = 1;
        tick();
        send(32'h00730313, 0, 32'h50, 0);
        expect_out("post_flush", 32'h50, 7, ALU_ADD, 6, 1, 0);
        drain();

        // Mid-stream reset
        ready_i = 0;
        send(32'h003100B3, 0, 8, 9);
        rst_n = 0;
        tick();
        @(negedge clk);
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.op1", op1_o, 32'd0);
        check("rst.op2", op2_o, 32'd0);
        check("rst.opcode", 32'(aluop_o), 32'd0);
        check("rst.rd", 32'(rd_o), 32'd0);
        check("rst.we", 32'(we_o), 32'd0);
        check("rst.illegal", 32'(ill_o), 32'd0);
        tick();
        rst_n = 1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            valid_i = ($urandom_range(0, 99) < 70);
            ready_i = ($urandom_range(0, 99) < 65);
            flush   = ($urandom_range(0, 99) < 3);
            instr   = rand_instr();
            pc      = $urandom;
            rs1     = $urandom;
            rs2     = $urandom;
            tick();
        end
        flush = 0;
        valid_i = 0;
        ready_i = 1;
        drain();
        @(negedge clk);
        check("final.empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
